// File: rtl/bus_arbiter.sv
// bus_arbiter: CPU/debug bus phase sequencer driving one-hot phase strobes and a bus sequence code.
// Optional `define BUS_ARB_WAIT_EN adds memory wait-stretching of COMMIT and a BUS_ERR timeout pulse.
module bus_arbiter #(
    parameter int MAX_WAIT = 15
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       halt_req,
    input  logic       cpu_mem_rd,
    input  logic       cpu_mem_wr,
    input  logic       dbg_req,
    input  logic       dbg_wr,
    output logic       fetch,
    output logic       decode,
    output logic       execute,
    output logic       commit,
    output logic [2:0] bus_seqx,
    output logic       stopped,
    output logic       dbg_ack
`ifdef BUS_ARB_WAIT_EN
    ,
    input  logic       mem_wait,
    output logic       bus_err
`endif
);
    typedef enum logic [3:0] {RST, F, D, E, C, S, DF, DD, DE, DC} state_t;
    state_t st, nx;
    logic [2:0] arg, arg_nx;
    logic [7:0] cnt;
    logic wt, busy, hold;
`ifdef BUS_ARB_WAIT_EN
    assign wt = mem_wait;
`else
    assign wt = 1'b0;
`endif
    // a commit stretches only while it actually drives a bus cycle and the timeout is not yet reached
    assign busy = (st == C || st == DC) && bus_seqx != 3'd0;
    assign hold = busy && wt && cnt != 8'(MAX_WAIT);
    always_comb begin
        nx = st;
        case (st)
            RST:     nx = halt_req ? S : F;
            F:       nx = D;
            D:       nx = E;
            E:       nx = C;
            C:       nx = hold ? C : halt_req ? S : F;
            S:       nx = dbg_ack ? S : dbg_req ? DF : halt_req ? S : F;
            DF:      nx = DD;
            DD:      nx = DE;
            DE:      nx = DC;
            DC:      nx = hold ? DC : S;
            default: nx = RST;
        endcase
    end
    assign arg_nx = st == E ? (cpu_mem_wr ? 3'd3 : cpu_mem_rd ? 3'd2 : 3'd0)
                  : (st == S && nx == DF) ? (dbg_wr ? 3'd6 : 3'd5) : arg;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st       <= RST;
            arg      <= 3'd0;
            cnt      <= 8'd0;
            fetch    <= 1'b0;
            decode   <= 1'b0;
            execute  <= 1'b0;
            commit   <= 1'b0;
            bus_seqx <= 3'd0;
            stopped  <= 1'b0;
            dbg_ack  <= 1'b0;
`ifdef BUS_ARB_WAIT_EN
            bus_err  <= 1'b0;
`endif
        end else begin
            st       <= nx;
            arg      <= arg_nx;
            cnt      <= hold ? cnt + 8'd1 : 8'd0;
            fetch    <= nx == F || nx == DF;
            decode   <= nx == D || nx == DD;
            execute  <= nx == E || nx == DE;
            commit   <= nx == C || nx == DC;
            bus_seqx <= (nx == C || nx == DC) ? arg_nx : nx == D ? 3'd1 : nx == DD ? 3'd4 : 3'd0;
            stopped  <= nx inside {S, DF, DD, DE, DC};
            dbg_ack  <= st == DC && nx == S;
`ifdef BUS_ARB_WAIT_EN
            bus_err  <= busy && cnt == 8'(MAX_WAIT);
`endif
        end
    end
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter: MAX_WAIT, default 15, maximum consecutive wait-state cycles in one COMMIT before forced completion (range 1..255).
REQ-002 CLK  input  1  single system clock, all state updates on rising edge.
REQ-003 RESET_N  input  1  reset, asynchronous assert, active-low.
REQ-004 HALT_REQ  input  1  debug request to stop the CPU at the next instruction boundary.
REQ-005 CPU_MEM_RD  input  1  current instruction needs an argument read, sampled during EXECUTE.
REQ-006 CPU_MEM_WR  input  1  current instruction needs an argument write, sampled during EXECUTE.
REQ-007 DBG_REQ  input  1  debug port requests one debug bus cycle, honoured only while stopped.
REQ-008 DBG_WR  input  1  debug cycle direction (1 = write), sampled with DBG_REQ.
REQ-009 WAIT  input  1  memory wait request, present only when BUS_ARB_WAIT_EN is defined.
REQ-010 FETCH, DECODE, EXECUTE, COMMIT  output  1 each  one-hot phase strobes to the bus interface.
REQ-011 BUS_SEQX  output  3  bus sequence code: IDLE=0, IFETCH=1, ARGRD=2, ARGWR=3, DFETCH=4, DARGRD=5, DARGWR=6.
REQ-012 STOPPED  output  1  CPU halted, no CPU bus traffic.
REQ-013 DBG_ACK  output  1  one-cycle pulse, debug cycle complete.
REQ-014 BUS_ERR  output  1  one-cycle pulse on wait timeout, present only when BUS_ARB_WAIT_EN is defined.

Function
REQ-015 All outputs are registered, with no combinational path from inputs to outputs.
REQ-016 FSM states: RST, F, D, E, C (CPU ring) and S (stopped), plus DF, DD, DE, DC (debug ring).
REQ-017 At most one of FETCH/DECODE/EXECUTE/COMMIT is high: FETCH is high in F/DF, DECODE in D/DD, EXECUTE in E/DE, COMMIT in C/DC; all four are low in RST and S.
REQ-018 CPU ring: F->D->E->C, one cycle each; after C, go to S if HALT_REQ=1, else go to F.
REQ-019 BUS_SEQX=IFETCH in D, and IDLE in F and E.
REQ-020 On the E->C edge, the CPU request is latched: CPU_MEM_WR=1 gives ARGWR (write wins if both are set), CPU_MEM_RD=1 gives ARGRD, otherwise IDLE; the latched code is driven throughout C.
REQ-021 STOPPED=1 in S and in the debug ring, and 0 elsewhere.
REQ-022 In S with DBG_ACK=0 and DBG_REQ=1: latch DBG_WR and go to DF.
REQ-023 In S with DBG_ACK=0, DBG_REQ=0 and HALT_REQ=0: go to F.
REQ-024 In S otherwise: stay in S.
REQ-025 Debug ring: DF->DD->DE->DC->S, one cycle each; BUS_SEQX=DFETCH in DD, DARGWR/DARGRD in DC per the latched DBG_WR, and IDLE in DF and DE.
REQ-026 DBG_ACK=1 exactly in the first S cycle after DC; a DBG_REQ still high in that cycle starts no cycle.
REQ-027 DBG_REQ outside S, and HALT_REQ changes during the debug ring, have no effect until S is re-entered.
REQ-028 HALT_REQ deasserted mid-debug-cycle: the debug ring completes, DBG_ACK pulses, and the next state is F.

Reset
REQ-029 RESET_N=0 immediately forces RST: phase strobes 0, BUS_SEQX=IDLE, STOPPED=0, DBG_ACK=0, BUS_ERR=0, and latched requests and the wait counter cleared.
REQ-030 On the first edge with RESET_N=1, RST goes to S if HALT_REQ=1, else to F.
REQ-031 Reset asserted mid-cycle (CPU or debug) aborts the cycle with no DBG_ACK.

Configuration
REQ-032 Macro BUS_ARB_WAIT_EN, when defined, adds WAIT, BUS_ERR and an 8-bit wait counter.
REQ-033 With BUS_ARB_WAIT_EN: in C/DC with BUS_SEQX != IDLE, WAIT=1 holds the state and BUS_SEQX for another cycle and increments the counter.
REQ-034 With BUS_ARB_WAIT_EN: when the counter reaches MAX_WAIT, the state advances regardless of WAIT, BUS_ERR pulses for one cycle, and the counter clears.
REQ-035 With BUS_ARB_WAIT_EN: WAIT is ignored when BUS_SEQX=IDLE and in every other state; the counter clears on leaving C/DC.
REQ-036 Without BUS_ARB_WAIT_EN: the WAIT and BUS_ERR ports are absent, and C/DC always last exactly one cycle.

Verification
REQ-037 Reset release with HALT_REQ=0, CPU_MEM_RD=CPU_MEM_WR=0 -> FETCH,DECODE,EXECUTE,COMMIT repeat on a 4-cycle period; BUS_SEQX is 1 in DECODE and 0 otherwise.
REQ-038 CPU_MEM_RD=1 in one EXECUTE, then CPU_MEM_WR=1 and CPU_MEM_RD=1 in the next -> BUS_SEQX=2 in the first COMMIT and 3 in the second.
REQ-039 HALT_REQ=1 raised during D -> after that C, STOPPED=1 and phases go low; DBG_REQ=1 with DBG_WR=0 -> DF..DC with BUS_SEQX 4 in DD and 5 in DC, then DBG_ACK for 1 cycle.
REQ-040 While stopped, DBG_WR=1 request held high through the ack -> exactly one debug cycle with BUS_SEQX=6 in DC; HALT_REQ=0 after the ack -> FETCH the next cycle.
REQ-041 RESET_N=0 asserted during DC -> all outputs are 0 asynchronously and no DBG_ACK pulses; release with HALT_REQ=1 -> S.
REQ-042 (BUS_ARB_WAIT_EN, MAX_WAIT=3) ARGRD with WAIT=1 for 2 cycles -> COMMIT lasts 3 cycles with no BUS_ERR; WAIT held high -> COMMIT lasts 4 cycles and BUS_ERR pulses once.
